// File: rtl/multi_vc_packet_injector.sv
// Packet injector: per-VC descriptor queues, round-robin VC arbitration and
// packet-atomic header/body/tail serialisation with per-VC credit flow control.
module multi_vc_packet_injector #(
    parameter int V        = 4,
    parameter int Fpay     = 32,
    parameter int EAw      = 8,
    parameter int PCK_SIZw = 8,
    parameter int QDEPTH   = 4,
    parameter int CRDTw    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [EAw-1:0]      current_e_addr,
    input  logic [V*CRDTw-1:0]  credit_init_val,
    input  logic                req_valid,
    input  logic [V-1:0]        req_vc,
    input  logic [EAw-1:0]      req_dest,
    input  logic [PCK_SIZw-1:0] req_size,
    output logic [V-1:0]        req_ready,
    output logic                req_err,
    output logic                flit_wr,
    output logic [V-1:0]        flit_vc,
    output logic                flit_hdr,
    output logic                flit_tail,
    output logic [Fpay-1:0]     flit_payload,
    input  logic [V-1:0]        credit_in,
    output logic                pck_sent,
    output logic                credit_err,
    output logic                busy
);
    localparam int QAW  = $clog2(QDEPTH);
    localparam int CNTW = QAW + 1;
    localparam int VIW  = (V > 1) ? $clog2(V) : 1;
    localparam logic [V-1:0]        ONE_VC  = V'(1);
    localparam logic [VIW-1:0]      LAST_VC = VIW'(V - 1);
    localparam logic [PCK_SIZw-1:0] ONE_SZ  = PCK_SIZw'(1);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t state, state_next;

    logic [EAw-1:0]      dest_mem [V][QDEPTH];
    logic [PCK_SIZw-1:0] size_mem [V][QDEPTH];
    logic [QAW-1:0]      wr_ptr [V];
    logic [QAW-1:0]      rd_ptr [V];
    logic [CNTW-1:0]     count [V];
    logic [CNTW-1:0]     count_next [V];
    logic [CRDTw-1:0]    credit [V];
    logic [CRDTw-1:0]    credit_init [V];

    logic [V-1:0]        push, pop, emit, eligible, nonempty;
    logic                push_ok, found;
    logic [VIW-1:0]      cand, grant_idx, cur_idx, cur_idx_next, rr_ptr, rr_ptr_next;
    logic [EAw-1:0]      head_dest;
    logic [PCK_SIZw-1:0] head_size, remaining, remaining_next, flit_idx, flit_idx_next;

    logic                wr_next, hdr_next, tail_next, sent_next;
    logic [V-1:0]        vc_next;
    logic [Fpay-1:0]     payload_next;

    // A full queue may still take a push when its head packet retires this cycle.
    always_comb begin
        push_ok = req_valid && $onehot(req_vc) && (req_size != '0) &&
                  ((req_vc & (req_ready | pop)) != '0);
        push    = push_ok ? req_vc : '0;
        for (int i = 0; i < V; i++) begin
            nonempty[i]   = (count[i] != '0);
            eligible[i]   = nonempty[i] && (credit[i] != '0);
            count_next[i] = count[i] + CNTW'(push[i]) - CNTW'(pop[i]);
        end
    end

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < V; k++) begin
            cand = VIW'((int'(rr_ptr) + k) % V);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        head_dest = dest_mem[grant_idx][rd_ptr[grant_idx]];
        head_size = size_mem[grant_idx][rd_ptr[grant_idx]];
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found && head_size != ONE_SZ) state_next = SEND;
            SEND:    if (credit[cur_idx] != '0 && remaining == ONE_SZ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_next        = 1'b0;
        hdr_next       = 1'b0;
        tail_next      = 1'b0;
        sent_next      = 1'b0;
        vc_next        = '0;
        payload_next   = '0;
        pop            = '0;
        emit           = '0;
        rr_ptr_next    = rr_ptr;
        cur_idx_next   = cur_idx;
        remaining_next = remaining;
        flit_idx_next  = flit_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    wr_next                   = 1'b1;
                    hdr_next                  = 1'b1;
                    vc_next                   = ONE_VC << grant_idx;
                    emit                      = ONE_VC << grant_idx;
                    payload_next[2*EAw-1:0]   = {head_dest, current_e_addr};
                    remaining_next            = head_size - ONE_SZ;
                    flit_idx_next             = ONE_SZ;
                    cur_idx_next              = grant_idx;
                    rr_ptr_next               = (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
                    if (head_size == ONE_SZ) begin
                        tail_next = 1'b1;
                        sent_next = 1'b1;
                        pop       = ONE_VC << grant_idx;
                    end
                end
            end
            SEND: begin
                if (credit[cur_idx] != '0) begin
                    wr_next                    = 1'b1;
                    vc_next                    = ONE_VC << cur_idx;
                    emit                       = ONE_VC << cur_idx;
                    payload_next[PCK_SIZw-1:0] = flit_idx;
                    remaining_next             = remaining - ONE_SZ;
                    flit_idx_next              = flit_idx + ONE_SZ;
                    if (remaining == ONE_SZ) begin
                        tail_next = 1'b1;
                        sent_next = 1'b1;
                        pop       = ONE_VC << cur_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flit_wr      <= 1'b0;
            flit_hdr     <= 1'b0;
            flit_tail    <= 1'b0;
            pck_sent     <= 1'b0;
            flit_vc      <= '0;
            flit_payload <= '0;
            req_err      <= 1'b0;
            rr_ptr       <= '0;
            cur_idx      <= '0;
            remaining    <= '0;
            flit_idx     <= '0;
        end else begin
            flit_wr      <= wr_next;
            flit_hdr     <= hdr_next;
            flit_tail    <= tail_next;
            pck_sent     <= sent_next;
            flit_vc      <= vc_next;
            flit_payload <= payload_next;
            req_err      <= req_valid && !push_ok;
            rr_ptr       <= rr_ptr_next;
            cur_idx      <= cur_idx_next;
            remaining    <= remaining_next;
            flit_idx     <= flit_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < V; i++) begin
            if (!reset) begin
                wr_ptr[i]    <= '0;
                rd_ptr[i]    <= '0;
                count[i]     <= '0;
                req_ready[i] <= 1'b1;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i]     <= count_next[i];
                req_ready[i] <= (count_next[i] < CNTW'(QDEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < V; i++) begin
            if (push[i]) begin
                dest_mem[i][wr_ptr[i]] <= req_dest;
                size_mem[i][wr_ptr[i]] <= req_size;
            end
        end
    end

    // Counters never exceed their init value; an excess return is flagged instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_err <= 1'b0;
            for (int i = 0; i < V; i++) begin
                credit_init[i] <= credit_init_val[i*CRDTw +: CRDTw];
                credit[i]      <= credit_init_val[i*CRDTw +: CRDTw];
            end
        end else begin
            for (int i = 0; i < V; i++) begin
                if (credit_in[i] && !emit[i]) begin
                    if (credit[i] == credit_init[i]) credit_err <= 1'b1;
                    else                             credit[i]  <= credit[i] + 1'b1;
                end else if (emit[i] && !credit_in[i]) begin
                    credit[i] <= credit[i] - 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE) || (|nonempty);

endmodule

// File: tb/tb_multi_vc_packet_injector.sv
// Self-checking bench: directed scenarios followed by a randomized phase, all
// compared every cycle against a queue-based packet-level reference model.
module tb_multi_vc_packet_injector;
    localparam int V      = 4;
    localparam int FPAY   = 32;
    localparam int EAW    = 8;
    localparam int PSW    = 8;
    localparam int QDEPTH = 4;
    localparam int CRDTW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [EAW-1:0]   current_e_addr;
    logic [V*CRDTW-1:0] credit_init_val;
    logic             req_valid;
    logic [V-1:0]     req_vc;
    logic [EAW-1:0]   req_dest;
    logic [PSW-1:0]   req_size;
    logic [V-1:0]     req_ready;
    logic             req_err;
    logic             flit_wr;
    logic [V-1:0]     flit_vc;
    logic             flit_hdr;
    logic             flit_tail;
    logic [FPAY-1:0]  flit_payload;
    logic [V-1:0]     credit_in;
    logic             pck_sent;
    logic             credit_err;
    logic             busy;

    multi_vc_packet_injector #(
        .V(V), .Fpay(FPAY), .EAw(EAW), .PCK_SIZw(PSW), .QDEPTH(QDEPTH), .CRDTw(CRDTW)
    ) dut (
        .clk(clk), .reset(reset), .current_e_addr(current_e_addr),
        .credit_init_val(credit_init_val), .req_valid(req_valid), .req_vc(req_vc),
        .req_dest(req_dest), .req_size(req_size), .req_ready(req_ready), .req_err(req_err),
        .flit_wr(flit_wr), .flit_vc(flit_vc), .flit_hdr(flit_hdr), .flit_tail(flit_tail),
        .flit_payload(flit_payload), .credit_in(credit_in), .pck_sent(pck_sent),
        .credit_err(credit_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: descriptor queues, credits and the packet in flight.
    int q_dest [V][$];
    int q_size [V][$];
    int m_cred [V];
    int m_init [V];
    int rr, pkt_vc, pkt_size, sent;
    bit in_pkt;

    logic            e_wr, e_hdr, e_tail, e_sent, e_err, e_cerr, e_busy;
    logic [V-1:0]    e_vc, e_ready;
    logic [FPAY-1:0] e_pay;

    logic [V-1:0] hdr_order [$];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_update();
        bit found;
        int pv, tv, popv;
        bit accepted;
        bit [V-1:0] dec;
        e_wr = 0; e_hdr = 0; e_tail = 0; e_sent = 0; e_vc = '0; e_pay = '0; e_err = 0;
        if (!reset) begin
            for (int i = 0; i < V; i++) begin
                q_dest[i].delete();
                q_size[i].delete();
                m_init[i] = int'(credit_init_val[i*CRDTW +: CRDTW]);
                m_cred[i] = m_init[i];
            end
            rr = 0; in_pkt = 0; e_cerr = 0; e_ready = '1; e_busy = 0;
            return;
        end
        dec = '0; popv = -1; found = 0; pv = 0;
        if (!in_pkt) begin
            for (int k = 0; k < V; k++) begin
                if (!found && q_size[(rr + k) % V].size() > 0 && m_cred[(rr + k) % V] > 0) begin
                    found = 1;
                    pv = (rr + k) % V;
                end
            end
            if (found) begin
                e_wr = 1; e_hdr = 1; e_vc = V'(1 << pv);
                e_pay = FPAY'((q_dest[pv][0] << EAW) | int'(current_e_addr));
                dec[pv] = 1;
                rr = (pv + 1) % V;
                pkt_vc = pv; pkt_size = q_size[pv][0]; sent = 1;
                if (pkt_size == 1) begin
                    e_tail = 1; e_sent = 1; popv = pv;
                end else begin
                    in_pkt = 1;
                end
            end
        end else if (m_cred[pkt_vc] > 0) begin
            e_wr = 1; e_vc = V'(1 << pkt_vc); e_pay = FPAY'(sent);
            dec[pkt_vc] = 1;
            sent++;
            if (sent == pkt_size) begin
                e_tail = 1; e_sent = 1; popv = pkt_vc; in_pkt = 0;
            end
        end
        tv = 0;
        for (int i = 0; i < V; i++) if (req_vc[i]) tv = i;
        accepted = req_valid && ($countones(req_vc) == 1) && (req_size != 0) &&
                   (q_size[tv].size() < QDEPTH || popv == tv);
        if (popv >= 0) begin
            void'(q_dest[popv].pop_front());
            void'(q_size[popv].pop_front());
        end
        if (accepted) begin
            q_dest[tv].push_back(int'(req_dest));
            q_size[tv].push_back(int'(req_size));
        end
        e_err = req_valid && !accepted;
        for (int i = 0; i < V; i++) begin
            if (credit_in[i] && !dec[i]) begin
                if (m_cred[i] == m_init[i]) e_cerr = 1;
                else m_cred[i]++;
            end else if (dec[i] && !credit_in[i]) begin
                m_cred[i]--;
            end
        end
        e_busy = in_pkt;
        for (int i = 0; i < V; i++) begin
            e_ready[i] = (q_size[i].size() < QDEPTH);
            if (q_size[i].size() > 0) e_busy = 1;
        end
    endtask

    task automatic check_all();
        check_output("flit_wr", 32'(flit_wr), 32'(e_wr));
        check_output("flit_vc", 32'(flit_vc), 32'(e_vc));
        check_output("flit_hdr", 32'(flit_hdr), 32'(e_hdr));
        check_output("flit_tail", 32'(flit_tail), 32'(e_tail));
        check_output("flit_payload", flit_payload, e_pay);
        check_output("pck_sent", 32'(pck_sent), 32'(e_sent));
        check_output("req_ready", 32'(req_ready), 32'(e_ready));
        check_output("req_err", 32'(req_err), 32'(e_err));
        check_output("credit_err", 32'(credit_err), 32'(e_cerr));
        check_output("busy", 32'(busy), 32'(e_busy));
    endtask

    // One clock: predict with the current inputs, take the edge, compare.
    task automatic apply_stimulus();
        model_update();
        @(posedge clk);
        #1;
        check_all();
        if (flit_wr === 1'b1 && flit_hdr === 1'b1) hdr_order.push_back(flit_vc);
    endtask

    task automatic push_desc(input int vc, input int dest, input int size);
        req_valid = 1'b1;
        req_vc    = V'(1 << vc);
        req_dest  = EAW'(dest);
        req_size  = PSW'(size);
        apply_stimulus();
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input int init);
        for (int i = 0; i < V; i++) credit_init_val[i*CRDTW +: CRDTW] = CRDTW'(init);
        credit_in = '0;
        req_valid = 1'b0;
        reset = 1'b0;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b1;
    endtask

    initial begin
        logic [V-1:0] exp_order [6];
        reset = 1'b0; req_valid = 1'b0; req_vc = '0; req_dest = '0; req_size = '0;
        credit_in = '0; current_e_addr = 8'h05; credit_init_val = '0;

        // Reset state and single 3-flit packet on VC1
        do_reset(4);
        check_output("reset_ready", 32'(req_ready), 32'hf);
        check_output("reset_wr", 32'(flit_wr), 32'h0);
        push_desc(1, 8'h12, 3);
        apply_stimulus();
        check_output("s1_hdr", 32'(flit_hdr), 32'h1);
        check_output("s1_hdr_vc", 32'(flit_vc), 32'h2);
        check_output("s1_hdr_payload", flit_payload, 32'h1205);
        apply_stimulus();
        check_output("s1_body1", flit_payload, 32'h1);
        apply_stimulus();
        check_output("s1_body2", flit_payload, 32'h2);
        check_output("s1_tail", 32'(flit_tail), 32'h1);
        check_output("s1_pck_sent", 32'(pck_sent), 32'h1);
        // VC1 has one credit left: header goes, first body stalls
        push_desc(1, 8'h34, 3);
        apply_stimulus();
        check_output("s1_hdr_last_credit", 32'(flit_wr), 32'h1);
        apply_stimulus();
        check_output("s1_stall_no_credit", 32'(flit_wr), 32'h0);

        // Single-flit packet
        do_reset(4);
        push_desc(0, 8'h44, 1);
        apply_stimulus();
        check_output("s2_hdr", 32'(flit_hdr), 32'h1);
        check_output("s2_tail", 32'(flit_tail), 32'h1);
        check_output("s2_pck_sent", 32'(pck_sent), 32'h1);
        apply_stimulus();
        check_output("s2_busy_low", 32'(busy), 32'h0);

        // Round-robin order across VC0/VC2/VC3, two rounds
        do_reset(4);
        hdr_order.delete();
        for (int r = 0; r < 2; r++) begin
            push_desc(0, 8'h10, 2);
            push_desc(2, 8'h20, 2);
            push_desc(3, 8'h30, 2);
        end
        for (int c = 0; c < 12; c++) apply_stimulus();
        exp_order = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        check_output("s3_hdr_count", 32'(hdr_order.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check_output("s3_rr_order", (i < hdr_order.size()) ? 32'(hdr_order[i]) : 32'hffff, 32'(exp_order[i]));

        // Credit stall and resume
        do_reset(2);
        push_desc(1, 8'h55, 4);
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("s4_stall", 32'(flit_wr), 32'h0);
        apply_stimulus();
        credit_in = 4'b0010;
        apply_stimulus();
        credit_in = '0;
        check_output("s4_stall_on_return", 32'(flit_wr), 32'h0);
        apply_stimulus();
        check_output("s4_resume", 32'(flit_wr), 32'h1);
        check_output("s4_resume_payload", flit_payload, 32'h2);
        credit_in = 4'b0010;
        apply_stimulus();
        credit_in = '0;
        apply_stimulus();
        check_output("s4_last_tail", 32'(flit_tail), 32'h1);

        // Queue full and rejected pushes
        do_reset(4);
        for (int i = 0; i < 4; i++) push_desc(3, 8'h60 + i, 8);
        check_output("s5_ready_full", 32'(req_ready), 32'h7);
        push_desc(3, 8'h99, 8);
        check_output("s5_err_full", 32'(req_err), 32'h1);
        check_output("s5_ready_still_full", 32'(req_ready), 32'h7);
        push_desc(0, 8'h11, 0);
        check_output("s5_err_size0", 32'(req_err), 32'h1);
        req_valid = 1'b1; req_vc = 4'b0011; req_size = 8'd2;
        apply_stimulus();
        req_valid = 1'b0;
        check_output("s5_err_not_onehot", 32'(req_err), 32'h1);

        // Reset in the middle of a packet
        do_reset(4);
        push_desc(1, 8'h77, 6);
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
        reset = 1'b1;
        check_output("s6_wr_after_reset", 32'(flit_wr), 32'h0);
        check_output("s6_ready_after_reset", 32'(req_ready), 32'hf);
        credit_in = 4'b0010;
        apply_stimulus();
        credit_in = '0;
        check_output("s6_credit_err", 32'(credit_err), 32'h1);
        apply_stimulus();

        // Randomized traffic
        do_reset(3);
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 400 != 0);
            if (!reset)
                for (int v = 0; v < V; v++)
                    credit_init_val[v*CRDTW +: CRDTW] = CRDTW'($urandom_range(1, 7));
            current_e_addr = EAW'($urandom);
            req_valid = ($urandom % 3 == 0);
            req_vc    = ($urandom % 10 == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V - 1));
            req_dest  = EAW'($urandom);
            req_size  = ($urandom % 10 == 0) ? PSW'(0) : PSW'($urandom_range(1, 5));
            for (int v = 0; v < V; v++)
                credit_in[v] = ((m_cred[v] < m_init[v]) && ($urandom % 3 == 0)) || ($urandom % 500 == 0);
            apply_stimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
